// File: rtl/ram_test_pkg.sv
// Shared definitions for the RAM test blocks: the FSM state encoding and the
// supported port-B read-latency range.
package ram_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Out-of-range latencies are pulled into the supported range.
    function automatic int clamp_rd_lat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/ram_rd_check_if.sv
// RAM port-B read bus: the checker is the master that issues reads, and the
// RAM is the slave that returns the data.
interface ram_rd_check_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (output ram_rd_en, output ram_rd_addr, input ram_rd_data);
    modport slave  (input ram_rd_en, input ram_rd_addr, output ram_rd_data);
endinterface

// File: rtl/ram_rd_pipe.sv
// Valid/address delay line. It matches the RAM read latency so that each
// issued address lines up with the read data that comes back for it.
module ram_rd_pipe #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr
);
    logic [RD_LAT-1:0] r_valid;
    logic [ADDR_W-1:0] r_addr [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_addr[0]  <= i_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign o_valid = r_valid[RD_LAT-1];
    assign o_addr  = r_addr[RD_LAT-1];
endmodule

// File: rtl/ram_rd_check.sv
// RAM read-back checker. On each rising edge of rd_flag it sweeps addresses
// 0..DEPTH-1 and compares each word against (addr + EXP_OFFSET).
module ram_rd_check
    import ram_test_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 64,
    parameter int RD_LAT     = 1,
    parameter int EXP_OFFSET = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              rd_flag,
    ram_rd_check_if.master    ram_bus,
    output logic              busy,
    output logic              pass_done,
    output logic [ADDR_W:0]   err_cnt,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam int                LAT        = clamp_rd_lat(RD_LAT);
    localparam int                CNT_W      = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAST_DRAIN = 2'(LAT - 1);
    localparam logic [CNT_W-1:0]  ERR_MAX    = CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0] OFFSET     = DATA_W'(EXP_OFFSET);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_rd_flag;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_drain_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_err_flag;
    logic [ADDR_W-1:0] r_first_err_addr;

    logic              w_rise;
    logic              w_start;
    logic              w_rd_en;
    logic              w_busy;
    logic              w_pass_done;
    logic              w_cmp_valid;
    logic [ADDR_W-1:0] w_cmp_addr;
    logic [DATA_W-1:0] w_exp_data;
    logic              w_mismatch;

    assign w_rise  = rd_flag & ~r_rd_flag;
    assign w_start = (r_state == ST_IDLE) && w_rise;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_rise) w_state_next = ST_READ;
            ST_READ:  if (r_addr == LAST_ADDR) w_state_next = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == LAST_DRAIN) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en     = 1'b0;
        w_busy      = 1'b1;
        w_pass_done = 1'b0;
        case (r_state)
            ST_IDLE:  w_busy      = 1'b0;
            ST_READ:  w_rd_en     = 1'b1;
            ST_DONE:  w_pass_done = 1'b1;
            default:  ;
        endcase
    end

    // Reset clears r_rd_flag to 0, so a flag already high at release counts as a rising edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rd_flag   <= 1'b0;
            r_addr      <= '0;
            r_drain_cnt <= 2'd0;
        end else begin
            r_rd_flag <= rd_flag;
            if (w_start) begin
                r_addr <= '0;
            end else if (r_state == ST_READ && r_addr != LAST_ADDR) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + 2'd1;
            else                     r_drain_cnt <= 2'd0;
        end
    end

    ram_rd_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (LAT)
    ) u_pipe (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_valid (w_rd_en),
        .i_addr  (r_addr),
        .o_valid (w_cmp_valid),
        .o_addr  (w_cmp_addr)
    );

    assign w_exp_data = DATA_W'(w_cmp_addr) + OFFSET;
    assign w_mismatch = w_cmp_valid && (ram_bus.ram_rd_data != w_exp_data);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_err_cnt        <= '0;
            r_err_flag       <= 1'b0;
            r_first_err_addr <= '0;
        end else begin
            if (w_start) begin
                r_err_cnt <= '0;
            end else if (w_mismatch && r_err_cnt != ERR_MAX) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_mismatch && !r_err_flag) begin
                r_err_flag       <= 1'b1;
                r_first_err_addr <= w_cmp_addr;
            end
        end
    end

    assign ram_bus.ram_rd_en   = w_rd_en;
    assign ram_bus.ram_rd_addr = r_addr;
    assign busy                = w_busy;
    assign pass_done           = w_pass_done;
    assign err_cnt             = r_err_cnt;
    assign err_flag            = r_err_flag;
    assign first_err_addr      = r_first_err_addr;
endmodule

// File: tb/tb_ram_rd_check.sv
// Self-checking bench for ram_rd_check: one default instance plus one with
// RD_LAT=2 and EXP_OFFSET=5, each attached to a behavioural RAM model.
module tb_ram_rd_check;
    import ram_test_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst0, rst1, flag0, flag1;
    logic          busy0, busy1, done0, done1, eflag0, eflag1;
    logic [AW:0]   ecnt0, ecnt1;
    logic [AW-1:0] fea0, fea1;
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] q0, q1a, q1b;

    ram_rd_check_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    ram_rd_check_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    ram_rd_check dut0 (
        .sys_clk(clk), .sys_rst(rst0), .rd_flag(flag0), .ram_bus(bus0),
        .busy(busy0), .pass_done(done0), .err_cnt(ecnt0), .err_flag(eflag0),
        .first_err_addr(fea0)
    );

    ram_rd_check #(.RD_LAT(2), .EXP_OFFSET(5)) dut1 (
        .sys_clk(clk), .sys_rst(rst1), .rd_flag(flag1), .ram_bus(bus1),
        .busy(busy1), .pass_done(done1), .err_cnt(ecnt1), .err_flag(eflag1),
        .first_err_addr(fea1)
    );

    // RAM models: one and two cycles of read latency.
    always @(posedge clk) begin
        if (bus0.ram_rd_en === 1'b1) q0 <= mem0[bus0.ram_rd_addr];
    end
    always @(posedge clk) begin
        if (bus1.ram_rd_en === 1'b1) q1a <= mem1[bus1.ram_rd_addr];
        q1b <= q1a;
    end
    assign bus0.ram_rd_data = q0;
    assign bus1.ram_rd_data = q1b;

    int checks = 0;
    int errors = 0;

    // Reference state: sticky error flag and first error address since reset.
    int   model_off [2] = '{0, 5};
    logic model_flag [2];
    int   model_first [2];

    int p_n_en, p_addr_ok, p_last_c, p_done_c, p_drain, p_extra_en, p_done_cnt;
    int p_ec_start, p_err_at_done, p_hit20, p_busy_end, p_ec_end;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int count_errs(input int d, output int first);
        int n;
        logic [DW-1:0] v, e;
        n = 0;
        first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            v = (d == 1) ? mem1[i] : mem0[i];
            e = DW'((i + model_off[d]) % 256);
            if (v !== e) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return n;
    endfunction

    task automatic set_flag(input int d, input logic v);
        if (d == 1) flag1 = v;
        else        flag0 = v;
    endtask

    task automatic sample(input int d, output logic en, output logic [AW-1:0] ad,
                          output logic pd, output logic bz, output logic [AW:0] ec);
        if (d == 1) begin
            en = bus1.ram_rd_en; ad = bus1.ram_rd_addr; pd = done1; bz = busy1; ec = ecnt1;
        end else begin
            en = bus0.ram_rd_en; ad = bus0.ram_rd_addr; pd = done0; bz = busy0; ec = ecnt0;
        end
    endtask

    // mode 0: plain pulse, 1: extra rd_flag edges during READ,
    // 2: stop when address 20 is issued, 3: flag already high (no new pulse)
    task automatic run_pass(input int d, input int mode);
        logic en, pd, bz;
        logic [AW-1:0] ad;
        logic [AW:0] ec;
        p_n_en = 0; p_addr_ok = 1; p_last_c = -1; p_done_c = -1; p_drain = 0;
        p_extra_en = 0; p_done_cnt = 0; p_ec_start = -1; p_err_at_done = -1;
        p_hit20 = 0; p_busy_end = 1; p_ec_end = -1;
        if (mode != 3) set_flag(d, 1'b1);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            sample(d, en, ad, pd, bz, ec);
            if (c == 0) p_ec_start = int'(ec);
            if (mode == 2 && en === 1'b1 && ad == AW'(20)) begin
                p_hit20 = 1;
                break;
            end
            if (en === 1'b1) begin
                if (p_done_c >= 0) p_extra_en++;
                else begin
                    if (ad !== AW'(p_n_en)) p_addr_ok = 0;
                    p_n_en++;
                    p_last_c = c;
                end
            end else if (bz === 1'b1 && pd !== 1'b1 && p_done_c < 0 && p_n_en > 0) begin
                p_drain++;
            end
            if (pd === 1'b1) begin
                p_done_cnt++;
                if (p_done_c < 0) begin
                    p_done_c = c;
                    p_err_at_done = int'(ec);
                end
            end
            if (c == 2) set_flag(d, 1'b0);
            if (mode == 1) begin
                if (c == 10 || c == 20) set_flag(d, 1'b1);
                if (c == 14 || c == 30) set_flag(d, 1'b0);
            end
            if (p_done_c >= 0 && c >= p_done_c + 60) begin
                p_busy_end = int'(bz);
                p_ec_end = int'(ec);
                break;
            end
        end
    endtask

    task automatic do_pass(input int d, input int mode, input int lat, input string tag);
        int exp_n, first;
        exp_n = count_errs(d, first);
        if (exp_n > 0 && !model_flag[d]) begin
            model_flag[d] = 1'b1;
            model_first[d] = first;
        end
        run_pass(d, mode);
        check({tag, ".n_en"}, p_n_en, DEPTH);
        check({tag, ".addr_seq"}, p_addr_ok, 1);
        check({tag, ".ec_start"}, p_ec_start, 0);
        check({tag, ".done_lat"}, p_done_c - p_last_c, lat + 1);
        check({tag, ".drain"}, p_drain, lat);
        check({tag, ".err_cnt"}, p_err_at_done, exp_n);
        check({tag, ".done_cnt"}, p_done_cnt, 1);
        check({tag, ".extra_en"}, p_extra_en, 0);
        check({tag, ".busy_end"}, p_busy_end, 0);
        check({tag, ".err_hold"}, p_ec_end, exp_n);
        check({tag, ".err_flag"}, (d == 1) ? eflag1 : eflag0, model_flag[d]);
        check({tag, ".first_err"}, (d == 1) ? fea1 : fea0, model_first[d]);
        $display("pass %s: reads=%0d err_cnt=%0d err_flag=%0d first_err_addr=%0d", tag,
                 p_n_en, p_err_at_done, (d == 1) ? eflag1 : eflag0, (d == 1) ? fea1 : fea0);
    endtask

    initial begin
        int seen, k, a;
        rst0 = 1'b1; rst1 = 1'b1; flag0 = 1'b0; flag1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = DW'(i);
            mem1[i] = DW'((i + 5) % 256);
        end
        model_flag = '{1'b0, 1'b0};
        model_first = '{0, 0};

        repeat (3) @(negedge clk);
        check("rst.en", bus0.ram_rd_en, 0);
        check("rst.addr", bus0.ram_rd_addr, 0);
        check("rst.busy", busy0, 0);
        check("rst.done", done0, 0);
        check("rst.err_cnt", ecnt0, 0);
        check("rst.err_flag", eflag0, 0);
        check("rst.first_err", fea0, 0);
        check("rst.busy1", busy1, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (3) @(negedge clk);
        check("idle.busy", busy0, 0);

        do_pass(0, 0, 1, "p_clean");
        mem0[10] = 8'hFF; mem0[40] = 8'h00;
        do_pass(0, 0, 1, "p_two_err");
        mem0[10] = 8'd10;
        do_pass(0, 0, 1, "p_fix10");
        do_pass(0, 1, 1, "p_toggle");
        mem0[40] = 8'd40;

        // Reset in the middle of a pass.
        run_pass(0, 2);
        check("rst_mid.hit20", p_hit20, 1);
        rst0 = 1'b1;
        #1;
        check("rst_mid.en", bus0.ram_rd_en, 0);
        check("rst_mid.addr", bus0.ram_rd_addr, 0);
        check("rst_mid.busy", busy0, 0);
        check("rst_mid.done", done0, 0);
        check("rst_mid.err_cnt", ecnt0, 0);
        check("rst_mid.err_flag", eflag0, 0);
        check("rst_mid.first_err", fea0, 0);
        $display("reset at address 20: busy=%0d err_flag=%0d", busy0, eflag0);
        model_flag[0] = 1'b0;
        model_first[0] = 0;
        @(negedge clk);
        rst0 = 1'b0;
        flag0 = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || done0 !== 1'b0) seen++;
        end
        check("rst_mid.quiet", seen, 0);
        do_pass(0, 0, 1, "p_after_rst");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) mem0[i] = DW'(i);
            k = int'($urandom_range(0, 4));
            for (int j = 0; j < k; j++) begin
                a = int'($urandom_range(0, DEPTH - 1));
                mem0[a] = DW'(a) ^ DW'($urandom_range(1, 255));
            end
            do_pass(0, 0, 1, $sformatf("p_rand%0d", r));
        end

        for (int i = 0; i < DEPTH; i++) mem0[i] = ~DW'(i);
        do_pass(0, 0, 1, "p_all_bad");
        for (int i = 0; i < DEPTH; i++) mem0[i] = DW'(i);

        // rd_flag already high when reset is released.
        @(negedge clk);
        rst0 = 1'b1;
        flag0 = 1'b1;
        model_flag[0] = 1'b0;
        model_first[0] = 0;
        @(negedge clk);
        rst0 = 1'b0;
        do_pass(0, 3, 1, "p_flag_at_rel");

        do_pass(1, 0, 2, "q_clean");
        mem1[0] = 8'h00;
        mem1[63] = 8'h00;
        do_pass(1, 0, 2, "q_edges");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
